// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: time-multiplexes NUM_DIGITS digits with per-slot blanking and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  output logic                    upd_ready,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_sync
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic                    pend_flag;
  logic                    slot_end;
  logic                    frame_end;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   lit;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign accept    = upd_valid && !pend_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      // A pending transfer holds upd_ready low, so the accept branch can only
      // fire on a frame_end when nothing was pending; it then waits a frame.
      if (frame_end && pend_flag) begin
        disp_reg  <= pend_reg;
        pend_flag <= 1'b0;
      end else if (accept) begin
        pend_reg  <= upd_data;
        pend_flag <= 1'b1;
      end
    end
  end

`ifdef SSD_LZB_EN
  logic zero_run;
  always_comb begin
    lit      = '1;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && (disp_reg[4*k +: 4] == 4'h0);
      lit[k]   = !zero_run;
    end
  end
`else
  assign lit = '1;
`endif

  always_comb begin
    an = '1;
    if (div_cnt >= BLANK_END && lit[idx])
      an[idx] = 1'b0;
  end

  assign digit_bcd  = disp_reg[4*idx +: 4];
  assign upd_ready  = !pend_flag;
  assign frame_sync = frame_end;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_ssd_scan_ctrl;

`ifdef SSD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0;
  logic        upd_ready;
  logic [3:0]  digit_bcd;
  logic [3:0]  an;
  logic        frame_sync;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_ready  (upd_ready),
    .digit_bcd  (digit_bcd),
    .an         (an),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        rdy;
    logic        fs;
    logic        nv;
    logic [15:0] nd;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_an, input logic [3:0] e_bcd,
                         input logic e_rdy, input logic e_fs);
    chk({tag, ".an"}, 32'(an), 32'(e_an));
    chk({tag, ".bcd"}, 32'(digit_bcd), 32'(e_bcd));
    chk({tag, ".rdy"}, 32'(upd_ready), 32'(e_rdy));
    chk({tag, ".fs"}, 32'(frame_sync), 32'(e_fs));
  endtask

  initial begin
    // Reset, first-slot blanking, and a single update applied at the frame boundary.
    tbl[0]  = '{0,  4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1,  4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{2,  4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{3,  4'hE, 4'h0, 1'b1, 1'b0, 1'b1, 16'h1234};
    tbl[4]  = '{4,  4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{8,  4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{10, LZB ? 4'hF : 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{31, LZB ? 4'hF : 4'h7, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{32, 4'hF, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{34, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{42, 4'hD, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{50, 4'hB, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[12] = '{58, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[13] = '{63, 4'h7, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[14] = '{64, 4'hF, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0000};

    #2;
    chk_all("reset_hold", 4'hF, 4'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    for (int i = 0; i < 15; i++) begin
      step_to(tbl[i].t);
      chk_all($sformatf("vec%0d", i), tbl[i].an, tbl[i].bcd, tbl[i].rdy, tbl[i].fs);
      upd_valid = tbl[i].nv;
      upd_data  = tbl[i].nd;
    end

    // Back-to-back: 2222 held valid must wait for the frame that applies 1111.
    upd_valid = 1'b1;
    upd_data  = 16'h1111;
    step();
    chk("b2b.rdy_after_1111", 32'(upd_ready), 32'd0);
    upd_data = 16'h2222;
    step_to(95);
    chk("b2b.fs", 32'(frame_sync), 32'd1);
    chk("b2b.rdy_at_fs", 32'(upd_ready), 32'd0);
    chk("b2b.bcd_old", 32'(digit_bcd), 32'h1);
    step();
    chk("b2b.rdy_after_fs", 32'(upd_ready), 32'd1);
    chk("b2b.bcd_1111", 32'(digit_bcd), 32'h1);
    step();
    upd_valid = 1'b0;
    chk("b2b.rdy_2222_taken", 32'(upd_ready), 32'd0);
    step_to(120);
    chk("b2b.bcd_d3_1111", 32'(digit_bcd), 32'h1);
    step_to(128);
    chk("b2b.bcd_2222", 32'(digit_bcd), 32'h2);

    // Collision: accept on the frame_sync cycle; applies one frame later.
    step_to(159);
    chk("col.fs", 32'(frame_sync), 32'd1);
    chk("col.rdy", 32'(upd_ready), 32'd1);
    upd_valid = 1'b1;
    upd_data  = 16'h5678;
    step();
    upd_valid = 1'b0;
    chk("col.rdy_after", 32'(upd_ready), 32'd0);
    chk("col.bcd_still_old", 32'(digit_bcd), 32'h2);
    step_to(191);
    chk("col.fs2", 32'(frame_sync), 32'd1);
    step_to(192);
    chk("col.bcd_d0", 32'(digit_bcd), 32'h8);
    step_to(202);
    chk("col.bcd_d1", 32'(digit_bcd), 32'h7);
    chk("col.an_d1", 32'(an), 32'hD);

    // Mid-operation reset between edges takes effect at once and discards all values.
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst", 4'hF, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // Free run: frame_sync at 31/63/95, scan pattern, never two anodes low.
    for (int i = 0; i < 100; i++) begin
      int div, idx;
      logic [3:0] e_an;
      div  = cyc % 8;
      idx  = (cyc / 8) % 4;
      e_an = 4'hF;
      if (div >= 2 && (!LZB || idx == 0)) e_an[idx] = 1'b0;
      chk("run.fs", 32'(frame_sync), 32'((cyc % 32) == 31));
      chk("run.an", 32'(an), 32'(e_an));
      chk("run.one_low", 32'($countones(~an) <= 1), 32'd1);
      chk("run.bcd", 32'(digit_bcd), 32'h0);
      step();
    end

    // 0050: leading zeros suppressed only when blanking is enabled.
    upd_valid = 1'b1;
    upd_data  = 16'h0050;
    step();
    upd_valid = 1'b0;
    step_to(130);
    chk("lzb.an_d0", 32'(an), 32'hE);
    chk("lzb.bcd_d0", 32'(digit_bcd), 32'h0);
    step_to(138);
    chk("lzb.an_d1", 32'(an), 32'hD);
    chk("lzb.bcd_d1", 32'(digit_bcd), 32'h5);
    step_to(146);
    chk("lzb.an_d2", 32'(an), LZB ? 32'hF : 32'hB);
    chk("lzb.bcd_d2", 32'(digit_bcd), 32'h0);
    step_to(154);
    chk("lzb.an_d3", 32'(an), LZB ? 32'hF : 32'h7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexing scan controller for an N-digit common-anode seven-segment display. It holds the displayed BCD word and selects one digit per refresh slot. It presents that digit's nibble to the BCD-to-7-segment decoder and drives the active-low anode enables. New values enter through a valid/ready port and are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= 4)
BLANK_CYC, 4, cycles at the start of each slot with all anodes off for anti-ghosting (< REFRESH_DIV)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
upd_valid  in  1  new display value offered
upd_data  in  4*NUM_DIGITS  new BCD value; digit k = bits [4k+3:4k]; digit 0 = rightmost
upd_ready  out  1  controller can accept a value this cycle
digit_bcd  out  4  nibble of the currently selected digit, to the decoder's BCD input
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while a digit is lit
frame_sync  out  1  one-cycle pulse when a frame completes

Behaviour:
- State registers: div_cnt (0..REFRESH_DIV-1), idx (0..NUM_DIGITS-1), disp_reg, pend_reg, pend_flag.
- All outputs are decoded from state registers only. There is no combinational path from any input to any output.
- Reset (asynchronous, takes effect immediately):
  - div_cnt=0, idx=0, disp_reg=0, pend_reg=0, pend_flag=0.
  - Outputs: an=all ones, digit_bcd=0, upd_ready=1, frame_sync=0.
- div_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and generates slot_end.
- On slot_end, idx increments; it wraps from NUM_DIGITS-1 to 0.
- frame_end = slot_end AND idx==NUM_DIGITS-1. frame_sync is high during exactly that cycle: one pulse per NUM_DIGITS*REFRESH_DIV cycles.
- digit_bcd = disp_reg[4*idx+3 : 4*idx] at all times, including during blanking.
- an:
  - all ones while div_cnt < BLANK_CYC.
  - otherwise bit idx = 0 and all other bits = 1.
- upd_ready = NOT pend_flag.
- Accept (upd_valid AND upd_ready): pend_reg <= upd_data, pend_flag <= 1. upd_data is ignored when upd_ready=0.
- On frame_end with pend_flag=1: disp_reg <= pend_reg, pend_flag <= 0. The new value appears from the first slot of the next frame (idx=0).
- Accept and frame_end in the same cycle (pend_flag was 0): data goes to pend_reg and is applied at the following frame_end, not the current one.
- pend_flag=1 at frame_end: upd_ready is 0 that cycle, so no new accept can collide with the transfer. upd_ready rises the next cycle.
- Non-BCD nibbles (A–F) pass through unmodified; the decoder renders them as hex.
- Reset mid-operation discards both the pending and the displayed value. The scan restarts at slot 0 with the blanking interval.

Optional Feature:
- Macro: SSD_LZB_EN (leading-zero blanking).
- Defined:
  - A digit k>0 is suppressed (its an bit held 1 for the whole slot) when digit k and every digit above it in disp_reg equal 0.
  - Digit 0 is never suppressed. digit_bcd is unaffected.
  - Suppression is re-evaluated combinationally from disp_reg.
- Undefined: all digits are lit in their slot, leading zeros included.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
1. Reset: assert rst between clock edges -> an=4'b1111, digit_bcd=0, upd_ready=1, frame_sync=0 immediately. Release rst -> first slot shows an=1111 for 2 cycles, then 1110 for 6 cycles.
2. Update: upd_valid=1, upd_data=16'h1234 in frame 0 -> upd_ready=0 the next cycle. After frame_sync, slots show digit_bcd 4,3,2,1 with an 1110,1101,1011,0111 (after blanking). upd_ready=1 again.
3. Back-to-back: offer 16'h1111, then hold 16'h2222 valid -> 2222 is not accepted until the cycle after the frame_sync that applies 1111. 2222 displays one frame later.
4. Collision: accept 16'h5678 exactly on a frame_sync cycle -> the next frame still shows the previous value. 5678 appears after the subsequent frame_sync.
5. Scan timing: free run 100 cycles -> frame_sync pulses at cycles 31, 63, 95 (one cycle wide). idx wraps 3->0, and an never has two bits low.
6. SSD_LZB_EN defined:
   - disp=16'h0050 -> digits 3 and 2 stay an=1 all slot; digit 1 lit with bcd 5; digit 0 lit with bcd 0.
   - disp=16'h0000 -> only digit 0 lit.
   - Macro undefined -> all four digits lit.
